// File: rtl/regfile_port_arbiter.sv
// Front end for the 32x64 dual-read/single-write register file: zero-clears every
// register after reset, then round-robins the register-file ports between requesters A and B.
module regfile_port_arbiter #(
    parameter int DATA_BITS = 64,
    parameter int ADDR_BITS = 5,
    parameter int NUM_REGS  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 init_done,

    input  logic                 a_req_valid,
    output logic                 a_req_ready,
    input  logic                 a_we,
    input  logic [ADDR_BITS-1:0] a_rw,
    input  logic [ADDR_BITS-1:0] a_ra,
    input  logic [ADDR_BITS-1:0] a_rb,
    input  logic [DATA_BITS-1:0] a_din,
    output logic                 a_rsp_valid,
    output logic [DATA_BITS-1:0] a_doutA,
    output logic [DATA_BITS-1:0] a_doutB,

    input  logic                 b_req_valid,
    output logic                 b_req_ready,
    input  logic                 b_we,
    input  logic [ADDR_BITS-1:0] b_rw,
    input  logic [ADDR_BITS-1:0] b_ra,
    input  logic [ADDR_BITS-1:0] b_rb,
    input  logic [DATA_BITS-1:0] b_din,
    output logic                 b_rsp_valid,
    output logic [DATA_BITS-1:0] b_doutA,
    output logic [DATA_BITS-1:0] b_doutB,

    output logic                 rf_we,
    output logic [ADDR_BITS-1:0] rf_rw,
    output logic [ADDR_BITS-1:0] rf_ra,
    output logic [ADDR_BITS-1:0] rf_rb,
    output logic [DATA_BITS-1:0] rf_din,
    input  logic [DATA_BITS-1:0] rf_doutA,
    input  logic [DATA_BITS-1:0] rf_doutB
);

    typedef enum logic [1:0] {
        RST_WAIT,
        CLR,
        RUN
    } state_e;

    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(NUM_REGS - 1);

    state_e               state_q;
    logic [ADDR_BITS-1:0] idx_q;
    logic                 init_done_q;
    logic                 last_b_q;     // 1: B was granted most recently
    logic                 rsp_valid_q;
    logic                 rsp_b_q;      // 1: pending response belongs to B

    logic run;
    logic grant_a;
    logic grant_b;

    assign run = (state_q == RUN);

    // On a tie the requester that was not granted last wins.
    assign grant_a = run & a_req_valid & (~b_req_valid | last_b_q);
    assign grant_b = run & b_req_valid & (~a_req_valid | ~last_b_q);

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;
    assign init_done   = init_done_q;

    // NOTE: every output gets a default before the branches, so no latch is inferred.
    always_comb begin
        rf_we  = 1'b0;
        rf_rw  = '0;
        rf_ra  = '0;
        rf_rb  = '0;
        rf_din = '0;
        if (state_q == CLR) begin
            rf_we = 1'b1;
            rf_rw = idx_q;
        end else if (grant_a) begin
            rf_we  = a_we;
            rf_rw  = a_rw;
            rf_ra  = a_ra;
            rf_rb  = a_rb;
            rf_din = a_din;
        end else if (grant_b) begin
            rf_we  = b_we;
            rf_rw  = b_rw;
            rf_ra  = b_ra;
            rf_rb  = b_rb;
            rf_din = b_din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the values present before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_WAIT;
            idx_q       <= '0;
            init_done_q <= 1'b0;
            last_b_q    <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_b_q     <= 1'b0;
        end else begin
            case (state_q)
                RST_WAIT: begin
                    state_q <= CLR;
                    idx_q   <= '0;
                end
                CLR: begin
                    if (idx_q == LAST_IDX) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + ADDR_BITS'(1);
                    end
                end
                RUN:     state_q <= RUN;
                default: state_q <= RST_WAIT;
            endcase

            rsp_valid_q <= grant_a | grant_b;
            rsp_b_q     <= grant_b;
            if (grant_a | grant_b) begin
                last_b_q <= grant_b;
            end
        end
    end

    // Register-file read data is steered only to the requester accepted last cycle.
    assign a_rsp_valid = rsp_valid_q & ~rsp_b_q;
    assign b_rsp_valid = rsp_valid_q &  rsp_b_q;
    assign a_doutA     = a_rsp_valid ? rf_doutA : '0;
    assign a_doutB     = a_rsp_valid ? rf_doutB : '0;
    assign b_doutA     = b_rsp_valid ? rf_doutA : '0;
    assign b_doutB     = b_rsp_valid ? rf_doutB : '0;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter: a behavioural register file with registered,
// read-before-write reads sits behind the arbiter; expected values are hand-computed.
module tb_regfile_port_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_done;
    logic          a_req_valid, a_req_ready, a_we, a_rsp_valid;
    logic [AW-1:0] a_rw, a_ra, a_rb;
    logic [DW-1:0] a_din, a_doutA, a_doutB;
    logic          b_req_valid, b_req_ready, b_we, b_rsp_valid;
    logic [AW-1:0] b_rw, b_ra, b_rb;
    logic [DW-1:0] b_din, b_doutA, b_doutB;
    logic          rf_we;
    logic [AW-1:0] rf_rw, rf_ra, rf_rb;
    logic [DW-1:0] rf_din, rf_doutA, rf_doutB;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mem [NR];

    always #5 clk = ~clk;

    regfile_port_arbiter #(.DATA_BITS(DW), .ADDR_BITS(AW), .NUM_REGS(NR)) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_we(a_we),
        .a_rw(a_rw), .a_ra(a_ra), .a_rb(a_rb), .a_din(a_din),
        .a_rsp_valid(a_rsp_valid), .a_doutA(a_doutA), .a_doutB(a_doutB),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_we(b_we),
        .b_rw(b_rw), .b_ra(b_ra), .b_rb(b_rb), .b_din(b_din),
        .b_rsp_valid(b_rsp_valid), .b_doutA(b_doutA), .b_doutB(b_doutB),
        .rf_we(rf_we), .rf_rw(rf_rw), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_din(rf_din),
        .rf_doutA(rf_doutA), .rf_doutB(rf_doutB)
    );

    // Register file model: registered reads return the pre-write value; garbage at start.
    initial begin
        for (int i = 0; i < NR; i++) mem[i] = 64'hBAD0_0000_0000_0000 | 64'(i + 1);
    end

    always @(posedge clk) begin
        rf_doutA <= mem[rf_ra];
        rf_doutB <= mem[rf_rb];
        if (rf_we) mem[rf_rw] <= rf_din;
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_a(input logic v, input logic we, input logic [AW-1:0] rw,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic [DW-1:0] din);
        a_req_valid = v; a_we = we; a_rw = rw; a_ra = ra; a_rb = rb; a_din = din;
    endtask

    task automatic set_b(input logic v, input logic we, input logic [AW-1:0] rw,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic [DW-1:0] din);
        b_req_valid = v; b_we = we; b_rw = rw; b_ra = ra; b_rb = rb; b_din = din;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Releases reset and walks the clear sequence edge by edge, with A pushing a request
    // that must be ignored until init_done.
    task automatic run_init();
        set_a(1'b1, 1'b1, 5'd20, 5'd0, 5'd0, 64'hFFFF);
        set_b(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("pre_edge_rf_we", 64'(rf_we), 64'd0);
        for (int k = 1; k <= NR + 1; k++) begin
            @(posedge clk);
            #1;
            if (k == NR + 1) set_a(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
            #1;
            if (k <= NR) begin
                check("clr_rf_we",     64'(rf_we),       64'd1);
                check("clr_rf_rw",     64'(rf_rw),       64'(k - 1));
                check("clr_rf_din",    rf_din,           64'd0);
                check("clr_a_ready",   64'(a_req_ready), 64'd0);
                check("clr_init_done", 64'(init_done),   64'd0);
            end else begin
                check("init_done",     64'(init_done),   64'd1);
                check("run_idle_we",   64'(rf_we),       64'd0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_a;
        set_a(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
        set_b(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
        #23;
        check("rst_init_done",   64'(init_done),   64'd0);
        check("rst_rf_we",       64'(rf_we),       64'd0);
        check("rst_rf_rw",       64'(rf_rw),       64'd0);
        check("rst_a_rsp_valid", 64'(a_rsp_valid), 64'd0);
        check("rst_b_doutA",     b_doutA,          64'd0);

        run_init();

        // Reg 5 reads back as cleared.
        set_a(1'b1, 1'b0, 5'd0, 5'd5, 5'd5, 64'h0);
        #1;
        check("rd5_a_ready", 64'(a_req_ready), 64'd1);
        check("rd5_rf_ra",   64'(rf_ra),       64'd5);
        step();
        set_a(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
        #1;
        check("rd5_rsp_valid", 64'(a_rsp_valid), 64'd1);
        check("rd5_doutA",     a_doutA,          64'd0);
        check("rd5_doutB",     a_doutB,          64'd0);
        check("rd5_b_rsp",     64'(b_rsp_valid), 64'd0);
        step();

        // A writes reg 3, then reads it back in the very next cycle.
        set_a(1'b1, 1'b1, 5'd3, 5'd0, 5'd0, 64'hDEAD_BEEF);
        #1;
        check("wr3_a_ready", 64'(a_req_ready), 64'd1);
        check("wr3_rf_we",   64'(rf_we),       64'd1);
        check("wr3_rf_rw",   64'(rf_rw),       64'd3);
        check("wr3_rf_din",  rf_din,           64'hDEAD_BEEF);
        step();
        set_a(1'b1, 1'b0, 5'd0, 5'd3, 5'd3, 64'h0);
        #1;
        check("wr3_rsp_valid", 64'(a_rsp_valid), 64'd1);
        check("wr3_b_rsp",     64'(b_rsp_valid), 64'd0);
        check("rd3_a_ready",   64'(a_req_ready), 64'd1);
        check("rd3_rf_we",     64'(rf_we),       64'd0);
        step();
        set_a(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
        #1;
        check("rd3_rsp_valid", 64'(a_rsp_valid), 64'd1);
        check("rd3_doutA",     a_doutA,          64'hDEAD_BEEF);
        check("rd3_doutB",     a_doutB,          64'hDEAD_BEEF);
        check("rd3_b_rsp",     64'(b_rsp_valid), 64'd0);
        check("rd3_b_doutA",   b_doutA,          64'd0);
        step();
        check("rd3_rsp_one_cycle", 64'(a_rsp_valid), 64'd0);
        check("idle_a_doutA",      a_doutA,          64'd0);

        // Only B valid: B writes regs 10..12 on consecutive cycles.
        for (int i = 0; i < 3; i++) begin
            set_b(1'b1, 1'b1, 5'(10 + i), 5'd0, 5'd0, 64'h1000 + 64'(i));
            #1;
            check("bonly_b_ready", 64'(b_req_ready), 64'd1);
            check("bonly_a_ready", 64'(a_req_ready), 64'd0);
            check("bonly_rf_rw",   64'(rf_rw),       64'(10 + i));
            if (i > 0) check("bonly_b_rsp", 64'(b_rsp_valid), 64'd1);
            step();
        end
        set_b(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
        #1;
        check("bonly_last_rsp", 64'(b_rsp_valid), 64'd1);
        check("bonly_a_rsp",    64'(a_rsp_valid), 64'd0);
        step();

        // Both valid for four cycles: grants alternate A, B, A, B.
        set_a(1'b1, 1'b0, 5'd0, 5'd10, 5'd11, 64'h0);
        set_b(1'b1, 1'b0, 5'd0, 5'd12, 5'd3,  64'h0);
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2 == 0);
            #1;
            check("tie_a_ready", 64'(a_req_ready), 64'(exp_a));
            check("tie_b_ready", 64'(b_req_ready), 64'(!exp_a));
            check("tie_rf_ra",   64'(rf_ra),       exp_a ? 64'd10 : 64'd12);
            if (i > 0) begin
                check("tie_a_rsp", 64'(a_rsp_valid), 64'(!exp_a));
                check("tie_b_rsp", 64'(b_rsp_valid), 64'(exp_a));
                if (!exp_a) begin
                    check("tie_a_doutA", a_doutA, 64'h1000);
                    check("tie_a_doutB", a_doutB, 64'h1001);
                end else begin
                    check("tie_b_doutA", b_doutA, 64'h1002);
                    check("tie_b_doutB", b_doutB, 64'hDEAD_BEEF);
                end
            end
            step();
        end
        set_a(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
        set_b(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
        #1;
        check("tie_last_b_rsp", 64'(b_rsp_valid), 64'd1);
        check("tie_last_a_rsp", 64'(a_rsp_valid), 64'd0);
        check("tie_last_doutA", b_doutA,          64'h1002);
        step();

        // Same-transaction read of the register being written returns the old value.
        set_a(1'b1, 1'b1, 5'd7, 5'd7, 5'd7, 64'h11);
        #1;
        check("rdw7_a_ready", 64'(a_req_ready), 64'd1);
        step();
        set_a(1'b1, 1'b0, 5'd0, 5'd7, 5'd7, 64'h0);
        #1;
        check("rdw7_rsp",   64'(a_rsp_valid), 64'd1);
        check("rdw7_doutA", a_doutA,          64'd0);
        check("rdw7_doutB", a_doutB,          64'd0);
        step();
        set_a(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
        #1;
        check("rd7_doutA", a_doutA, 64'h11);
        check("rd7_doutB", a_doutB, 64'h11);
        step();

        // Reset while A's read of reg 3 has its response pending.
        set_a(1'b1, 1'b0, 5'd0, 5'd3, 5'd3, 64'h0);
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_a_rsp",     64'(a_rsp_valid), 64'd0);
        check("mid_rst_a_doutA",   a_doutA,          64'd0);
        check("mid_rst_init_done", 64'(init_done),   64'd0);
        check("mid_rst_a_ready",   64'(a_req_ready), 64'd0);
        check("mid_rst_rf_ra",     64'(rf_ra),       64'd0);
        step();
        check("mid_rst_a_rsp_hold", 64'(a_rsp_valid), 64'd0);

        run_init();

        // Pointer is back at B, so A wins the first tie; reg 3 was cleared again.
        set_a(1'b1, 1'b0, 5'd0, 5'd3, 5'd3, 64'h0);
        set_b(1'b1, 1'b0, 5'd0, 5'd5, 5'd5, 64'h0);
        #1;
        check("post_rst_a_ready", 64'(a_req_ready), 64'd1);
        check("post_rst_b_ready", 64'(b_req_ready), 64'd0);
        step();
        set_a(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
        set_b(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
        #1;
        check("post_rst_a_rsp",   64'(a_rsp_valid), 64'd1);
        check("post_rst_reg3",    a_doutA,          64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Sequencer and arbiter in front of the 32×64-bit dual-read/single-write register file. After reset it zero-clears every register, then shares the register file's single write port and two read ports between two requesters (A and B) with round-robin arbitration and a valid/ready handshake. Read data returns to the granted requester one cycle after acceptance, matching the register file's registered read.

## Interface
- DATA_BITS, 64, register width
- ADDR_BITS, 5, register index width
- NUM_REGS, 32, registers cleared by the init sequence (≤ 2^ADDR_BITS)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- init_done  out  1  high once the clear sequence is complete
- {a,b}_req_valid  in  1  requester has a transaction
- {a,b}_req_ready  out  1  transaction accepted this cycle (valid && ready)
- {a,b}_we  in  1  transaction includes a write
- {a,b}_rw, {a,b}_ra, {a,b}_rb  in  ADDR_BITS  write / read-A / read-B index
- {a,b}_din  in  DATA_BITS  write data
- {a,b}_rsp_valid  out  1  read data valid for this requester
- {a,b}_doutA, {a,b}_doutB  out  DATA_BITS  read data
- rf_we  out  1  register-file write enable
- rf_rw, rf_ra, rf_rb  out  ADDR_BITS  register-file indices
- rf_din  out  DATA_BITS  register-file write data
- rf_doutA, rf_doutB  in  DATA_BITS  register-file registered read data

## Operation
- States: RST_WAIT (reset value) → CLR → RUN.
- RST_WAIT: all rf outputs 0, readies 0. Moves to CLR on the first clk edge after rst_n rises.
- CLR: clear counter idx runs from 0 to NUM_REGS-1. Drives rf_we=1, rf_rw=idx, rf_din=0, rf_ra=rf_rb=0. Readies stay 0. The edge at idx=NUM_REGS-1 moves to RUN.
- RUN: init_done=1. Exactly one requester is granted per cycle.
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last wins. The last-granted pointer resets to B, so A wins the first tie.
  - Pointer updates only on an accept.
- The winner's ready=1 combinationally, and its we/rw/din/ra/rb pass straight to the rf_* outputs. The loser's ready=0, and it must hold its request stable until accepted.
- No accept: rf_we=0, rf_rw=rf_ra=rf_rb=0, rf_din=0.
- Response: a registered 1-bit tag records which requester was accepted in cycle N. In cycle N+1, that requester's rsp_valid=1, and its doutA/doutB = rf_doutA/rf_doutB (combinational pass-through). Every accept gets a response, including write-only transactions; the caller ignores the data.
- Non-selected dout outputs are 0, so there is no stale data.
- Read-during-write in the same accepted transaction returns the pre-write value. A write accepted in cycle N is visible to any read accepted in cycle N+1 or later.
- Reset mid-operation: async return to RST_WAIT, counter 0, pointer = B, rsp tag cleared. An in-flight response is dropped, and the full clear sequence reruns.

## Timing
- Reset values: init_done=0, all readies 0, all rsp_valid 0, all douts 0, rf_we=0, all rf indices and rf_din 0.
- init_done first high in the cycle after NUM_REGS+1 rising edges following reset release (33 with the default).
- Throughput: one transaction per cycle sustained, back-to-back across requesters.
- Latency: accept in cycle N → rsp_valid high for exactly one cycle, N+1.
- No combinational path from rf_doutA/B to any ready.
- Paths exist from req_valid to ready and to the rf_* outputs.

## Test plan
- Reset release: count edges. rf_we pulses with rf_rw=0..31 and rf_din=0, then init_done=1 at edge 33. Reading reg 5 afterwards returns 0.
- A writes reg 3 = 0xDEAD_BEEF (accepted cycle N). A reads ra=3 in cycle N+1 → a_rsp_valid in N+2 with a_doutA = 0xDEAD_BEEF. b_rsp_valid stays 0 throughout.
- A and B both hold valid for 4 cycles. Grants alternate A, B, A, B, and each rsp_valid follows its own accept by one cycle.
- Single transaction: A writes reg 7 = 0x11 while reading ra=7, rb=7 → response shows the old value 0. A following read returns 0x11.
- Only B valid for 3 cycles → B is granted every cycle, and a_req_ready stays 0.
- Assert rst_n low during RUN with a response pending → all outputs reach reset values immediately, no rsp_valid appears, and the clear sequence restarts from idx 0 after release.
